// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, IF/ID field widths and
// the NOP word used for cleared instruction slots.
package fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Sequential-address increment; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Generic pipeline register: load captures a real instruction, bubble only
// clears Valid, neither control holds every field.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_bubble,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic [PC_W-1:0]    i_pcplus4,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [PC_W-1:0]    o_pcplus4,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instruction;
    logic [PC_W-1:0]    r_pcplus4;
    logic               r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instruction <= NOP;
            r_pcplus4     <= '0;
            r_valid       <= 1'b0;
        end else if (i_load) begin
            r_instruction <= i_instruction;
            r_pcplus4     <= i_pcplus4;
            r_valid       <= 1'b1;
        end else if (i_bubble) begin
            r_valid       <= 1'b0;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pcplus4     = r_pcplus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request/ack port to instruction memory with a
// one-entry skid buffer, squash of in-flight fetches, and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_ifid_instruction,
    output logic [PC_W-1:0]    o_ifid_pcplus4,
    output logic               o_ifid_valid,
    output logic               o_fetch_busy
);

    localparam logic [PC_W-1:0] RESET_PC_A = RESET_PC & ~32'h3;

    fetch_state_e       r_state, w_state_next;
    logic [PC_W-1:0]    r_pc, w_pc_next;
    logic [PC_W-1:0]    r_req_addr;
    logic [INSTR_W-1:0] r_hold_buf, w_hold_buf_next;
    logic               w_load, w_bubble;
    logic [INSTR_W-1:0] w_load_instr;
    logic [PC_W-1:0]    w_redir_target;
    logic               w_redir_ok;

    assign w_redir_target = i_redirect_pc & ~32'h3;
    // Branch operands are not valid during a load-use stall, so stall wins.
    assign w_redir_ok     = i_redirect & ~i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC_A;
            r_req_addr <= RESET_PC_A;
            r_hold_buf <= NOP;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_hold_buf <= w_hold_buf_next;
            if (r_state == ST_FETCH)
                r_req_addr <= r_pc;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_hold_buf_next = r_hold_buf;
        w_load          = 1'b0;
        w_load_instr    = i_imem_rdata;
        unique case (r_state)
            ST_FETCH: begin
                if (i_imem_ack) begin
                    if (i_stall) begin
                        w_hold_buf_next = i_imem_rdata;
                        w_state_next    = ST_HOLD;
                    end else if (i_redirect) begin
                        w_pc_next = w_redir_target;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = pc_plus4(r_pc);
                    end
                end else if (w_redir_ok) begin
                    w_pc_next    = w_redir_target;
                    w_state_next = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                w_load_instr = r_hold_buf;
                if (!i_stall) begin
                    w_state_next = ST_FETCH;
                    if (i_redirect) begin
                        w_pc_next = w_redir_target;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = pc_plus4(r_pc);
                    end
                end
            end
            ST_DISCARD: begin
                // The squashed request must complete before a new address goes out.
                if (w_redir_ok)
                    w_pc_next = w_redir_target;
                if (i_imem_ack)
                    w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    assign w_bubble = ~i_stall & ~w_load;

    assign o_imem_req   = (r_state != ST_HOLD);
    assign o_imem_addr  = (r_state == ST_DISCARD) ? r_req_addr : r_pc;
    assign o_fetch_busy = (r_state == ST_FETCH) || (r_state == ST_DISCARD);

    ifid_reg u_ifid (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_load),
        .i_bubble      (w_bubble),
        .i_instruction (w_load_instr),
        .i_pcplus4     (pc_plus4(r_pc)),
        .o_instruction (o_ifid_instruction),
        .o_pcplus4     (o_ifid_pcplus4),
        .o_valid       (o_ifid_valid)
    );

endmodule
